// File: rtl/matrix_rd_pkg.sv
// Shared state type, register map and helpers
// for the matrix tile read engine.
package matrix_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

    localparam int N_CTRL       = 8;
    localparam int N_STAT       = 16;

    localparam int CTRL_BASE_LO = 0;
    localparam int CTRL_BASE_HI = 1;
    localparam int CTRL_OPS     = 2;
    localparam int CTRL_GROUPS  = 3;
    localparam int CTRL_BURST   = 4;
    localparam int CTRL_GSIZE   = 5;
    localparam int CTRL_STRIDE  = 6;
    localparam int CTRL_ABORT   = 7;

    localparam int STAT_FLAGS   = 0;
    localparam int STAT_ISSUED  = 1;
    localparam int STAT_RLAST   = 2;
    localparam int STAT_ERRORS  = 3;
    localparam int STAT_CYCLES  = 4;
    localparam int STAT_BEATS   = 5;

    function automatic int beat_bytes_log2(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/axi_mm.sv
// AXI4 memory-mapped bundle; the read engine
// drives AR/R and parks AW/W/B.
interface axi_mm #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int ID_WIDTH   = 4
);
    logic [ID_WIDTH-1:0]     arid;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic                    arvalid;
    logic                    arready;
    logic [ID_WIDTH-1:0]     rid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;
    logic [ID_WIDTH-1:0]     awid;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [ID_WIDTH-1:0]     bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst,
        output arlock, arcache, arprot, arqos, arregion,
        output arvalid, rready,
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        input  arready, rid, rdata, rresp, rlast, rvalid,
        input  awready, wready, bid, bresp, bvalid
    );
endinterface

// File: rtl/matrix_rd_addr_gen.sv
// Burst address generator: accumulating group base
// plus an offset wrapped inside a power-of-two window.
module matrix_rd_addr_gen #(
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [ADDR_WIDTH-1:0] stride,
    input  logic [ADDR_WIDTH-1:0] mask,
    input  logic [ADDR_WIDTH-1:0] step,
    input  logic                  advance,
    input  logic                  next_group,
    output logic [ADDR_WIDTH-1:0] addr
);
    logic [ADDR_WIDTH-1:0] grp_base;
    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0] mask_q;
    logic [ADDR_WIDTH-1:0] step_q;
    logic [ADDR_WIDTH-1:0] off_nxt;
    logic [ADDR_WIDTH-1:0] grp_nxt;

    assign off_nxt = off + step_q;
    assign grp_nxt = grp_base + stride_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            grp_base <= '0;
            off      <= '0;
            stride_q <= '0;
            mask_q   <= '0;
            step_q   <= '0;
            addr     <= '0;
        end else if (load) begin
            grp_base <= base;
            off      <= '0;
            stride_q <= stride;
            mask_q   <= mask;
            step_q   <= step;
            addr     <= base;
        end else if (advance) begin
            if (next_group) begin
                grp_base <= grp_nxt;
                off      <= '0;
                addr     <= grp_nxt;
            end else begin
                off      <= off_nxt;
                addr     <= grp_base + (off_nxt & mask_q);
            end
        end
    end
endmodule

// File: rtl/matrix_read_engine.sv
// AXI4 read engine streaming matrix tiles: FSM,
// outstanding-read credits and status counters.
module matrix_read_engine
    import matrix_rd_pkg::*;
#(
    parameter int DATA_WIDTH      = 512,
    parameter int ADDR_WIDTH      = 64,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic        clk,
    input  logic        rstn,
    axi_mm.master       matrix,
    input  logic        start,
    input  logic [31:0] control_reg [N_CTRL],
    output logic [31:0] status_reg  [N_STAT]
);
    localparam int BEAT_LOG2 = beat_bytes_log2(DATA_WIDTH);
    localparam int CW        = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CW-1:0] CMAX = CW'(MAX_OUTSTANDING);

    rd_state_t state, state_n;
    logic start_q, launch, cfg_zero, abort;
    logic ar_hs, r_beat, r_done, op_last, last_hs;
    logic ar_valid, arvalid_n, abort_exit;
    logic busy, done, aborted;
    logic [CW-1:0] credits, credits_n;
    logic [31:0] ops_s, grps_s, op_idx, grp_idx;
    logic [7:0] arlen_s;
    logic [31:0] issued, rlasts, errors, cycles, beats;
    logic [ADDR_WIDTH-1:0] ar_addr, base_cfg;

    assign abort    = control_reg[CTRL_ABORT][0];
    assign launch   = state == IDLE && start && !start_q;
    assign cfg_zero = control_reg[CTRL_OPS] == 32'd0
                   || control_reg[CTRL_GROUPS] == 32'd0;
    assign ar_hs    = ar_valid && matrix.arready;
    assign r_beat   = matrix.rvalid;
    assign r_done   = r_beat && matrix.rlast;
    assign op_last  = op_idx == ops_s - 32'd1;
    assign last_hs  = ar_hs && op_last && grp_idx == grps_s - 32'd1;
    assign base_cfg = ADDR_WIDTH'({control_reg[CTRL_BASE_HI],
                                   control_reg[CTRL_BASE_LO]});

    matrix_rd_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr (
        .clk        (clk),
        .rstn       (rstn),
        .load       (launch),
        .base       (base_cfg),
        .stride     (ADDR_WIDTH'(control_reg[CTRL_STRIDE])),
        .mask       (ADDR_WIDTH'(control_reg[CTRL_GSIZE] - 32'd1)),
        .step       (ADDR_WIDTH'(control_reg[CTRL_BURST])),
        .advance    (ar_hs),
        .next_group (op_last),
        .addr       (ar_addr)
    );

    // A stray beat with no credit outstanding must not underflow.
    always_comb begin
        credits_n = credits;
        if (ar_hs && !r_done)
            credits_n = credits + CW'(1);
        else if (r_done && !ar_hs && credits != '0)
            credits_n = credits - CW'(1);
    end

    always_comb begin
        state_n    = state;
        arvalid_n  = 1'b0;
        abort_exit = 1'b0;
        unique case (state)
            IDLE: if (launch) state_n = cfg_zero ? DONE : ISSUE;
            ISSUE: begin
                if (last_hs) begin
                    state_n = DRAIN;
                end else if (abort && !ar_valid) begin
                    state_n    = DRAIN;
                    abort_exit = 1'b1;
                end else if (ar_valid && !ar_hs) begin
                    arvalid_n = 1'b1;
                end else begin
                    arvalid_n = !abort && credits_n < CMAX;
                end
            end
            DRAIN: if (credits == '0) state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            ar_valid <= 1'b0;
            credits  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            ops_s    <= '0;
            grps_s   <= '0;
            arlen_s  <= '0;
            op_idx   <= '0;
            grp_idx  <= '0;
        end else begin
            state    <= state_n;
            start_q  <= start;
            ar_valid <= arvalid_n;
            credits  <= credits_n;
            if (launch) begin
                busy    <= 1'b1;
                done    <= 1'b0;
                aborted <= 1'b0;
                ops_s   <= control_reg[CTRL_OPS];
                grps_s  <= control_reg[CTRL_GROUPS];
                arlen_s <= 8'((control_reg[CTRL_BURST] >> BEAT_LOG2) - 32'd1);
                op_idx  <= '0;
                grp_idx <= '0;
            end else if (state == DONE) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
            if (abort_exit) aborted <= 1'b1;
            if (ar_hs) begin
                if (op_last) begin
                    op_idx  <= '0;
                    grp_idx <= grp_idx + 32'd1;
                end else begin
                    op_idx  <= op_idx + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issued <= '0;
            rlasts <= '0;
            errors <= '0;
            cycles <= '0;
            beats  <= '0;
        end else if (launch) begin
            issued <= '0;
            rlasts <= '0;
            errors <= '0;
            cycles <= '0;
            beats  <= '0;
        end else begin
            if (ar_hs)  issued <= sat_inc(issued);
            if (r_done) rlasts <= sat_inc(rlasts);
            if (r_beat && matrix.rresp[1]) errors <= sat_inc(errors);
            if (busy)   cycles <= sat_inc(cycles);
            if (r_beat) beats  <= sat_inc(beats);
        end
    end

    always_comb begin
        for (int i = 0; i < N_STAT; i++) status_reg[i] = '0;
        status_reg[STAT_FLAGS]  = {25'd0, aborted, done, busy, 2'b00, state};
        status_reg[STAT_ISSUED] = issued;
        status_reg[STAT_RLAST]  = rlasts;
        status_reg[STAT_ERRORS] = errors;
        status_reg[STAT_CYCLES] = cycles;
        status_reg[STAT_BEATS]  = beats;
    end

    assign matrix.arid     = ID_WIDTH'(0);
    assign matrix.araddr   = ar_addr;
    assign matrix.arlen    = arlen_s;
    assign matrix.arsize   = 3'(BEAT_LOG2);
    assign matrix.arburst  = 2'b01;
    assign matrix.arlock   = 1'b0;
    assign matrix.arcache  = 4'd0;
    assign matrix.arprot   = 3'b010;
    assign matrix.arqos    = 4'd0;
    assign matrix.arregion = 4'd0;
    assign matrix.arvalid  = ar_valid;
    assign matrix.rready   = 1'b1;
    assign matrix.awid     = '0;
    assign matrix.awaddr   = '0;
    assign matrix.awlen    = '0;
    assign matrix.awsize   = '0;
    assign matrix.awburst  = '0;
    assign matrix.awvalid  = 1'b0;
    assign matrix.wdata    = '0;
    assign matrix.wstrb    = '0;
    assign matrix.wlast    = 1'b0;
    assign matrix.wvalid   = 1'b0;
    assign matrix.bready   = 1'b0;

    // R data is consumed by the datapath tap, not here.
    logic unused_inputs;
    assign unused_inputs = ^{matrix.rid, matrix.rdata, matrix.rresp[0],
                             matrix.awready, matrix.wready, matrix.bid,
                             matrix.bresp, matrix.bvalid,
                             control_reg[CTRL_ABORT][31:1]};
endmodule

// File: tb/tb_matrix_read_engine.sv
// Directed bench for matrix_read_engine with a
// scripted AXI read slave.
module tb_matrix_read_engine;
    import matrix_rd_pkg::*;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [31:0] ctrl [N_CTRL];
    logic [31:0] stat [N_STAT];

    int pass_cnt = 0;
    int total_cnt = 0;

    bit r_en = 0;
    bit err_mode = 0;
    int hs_cnt = 0;
    int tb_beats = 0;
    int beat_idx = 0;
    int len_q [$];
    logic [63:0] addr_log [$];
    logic [7:0]  len_log [$];

    axi_mm #(.ADDR_WIDTH(64), .DATA_WIDTH(512), .ID_WIDTH(4)) axi_if ();

    matrix_read_engine #(
        .DATA_WIDTH(512), .ADDR_WIDTH(64),
        .ID_WIDTH(4), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .rstn(rstn), .matrix(axi_if),
        .start(start), .control_reg(ctrl), .status_reg(stat)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Read slave: one beat per cycle while enabled; logs AR handshakes.
    initial begin
        axi_if.rvalid = 0; axi_if.rlast = 0; axi_if.rresp = 0;
        axi_if.rdata = '0; axi_if.rid = '0;
        forever begin
            @(negedge clk);
            axi_if.rvalid = 0; axi_if.rlast = 0; axi_if.rresp = 0;
            if (!rstn) begin
                len_q.delete();
                beat_idx = 0;
            end else begin
                if (r_en && len_q.size() > 0) begin
                    axi_if.rvalid = 1;
                    axi_if.rlast = (beat_idx == len_q[0]);
                    axi_if.rresp = (err_mode && (tb_beats == 3 || tb_beats == 12))
                                   ? 2'b10 : 2'b00;
                    axi_if.rdata = {16{tb_beats}};
                    tb_beats++;
                    if (axi_if.rlast) begin
                        void'(len_q.pop_front());
                        beat_idx = 0;
                    end else begin
                        beat_idx++;
                    end
                end
                if (axi_if.arvalid && axi_if.arready) begin
                    len_q.push_back(int'(axi_if.arlen));
                    addr_log.push_back(axi_if.araddr);
                    len_log.push_back(axi_if.arlen);
                    hs_cnt++;
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cfg(input logic [63:0] base, input int ops, input int grps,
                       input int burst, input int gsize, input int stride);
        ctrl[CTRL_BASE_LO] = base[31:0];
        ctrl[CTRL_BASE_HI] = base[63:32];
        ctrl[CTRL_OPS]     = ops;
        ctrl[CTRL_GROUPS]  = grps;
        ctrl[CTRL_BURST]   = burst;
        ctrl[CTRL_GSIZE]   = gsize;
        ctrl[CTRL_STRIDE]  = stride;
        ctrl[CTRL_ABORT]   = 0;
        hs_cnt = 0;
        tb_beats = 0;
        addr_log.delete();
        len_log.delete();
    endtask

    task automatic start_run();
        start = 1;
        tick();
        start = 0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (stat[STAT_FLAGS][5]) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int nz;
        rstn = 0;
        tick(3);
        nz = 0;
        for (int i = 0; i < N_STAT; i++) if (stat[i] !== 32'd0) nz++;
        total_cnt++;
        if (nz !== 0) $display("FAIL reset_status: %0d nonzero regs, exp 0", nz);
        else pass_cnt++;
        total_cnt++;
        if (axi_if.arvalid !== 1'b0) $display("FAIL reset_arvalid: got %b exp 0", axi_if.arvalid);
        else pass_cnt++;
        total_cnt++;
        if (axi_if.araddr !== 64'd0) $display("FAIL reset_araddr: got %h exp 0", axi_if.araddr);
        else pass_cnt++;
        total_cnt++;
        if (axi_if.rready !== 1'b1) $display("FAIL reset_rready: got %b exp 1", axi_if.rready);
        else pass_cnt++;
        rstn = 1;
        tick(2);
    endtask

    task automatic test_wrap_addresses();
        logic [63:0] exp_a [8];
        logic [63:0] got;
        bit ok;
        int badlen;
        exp_a = '{64'h1000, 64'h1200, 64'h1000, 64'h1200,
                  64'h11000, 64'h11200, 64'h11000, 64'h11200};
        cfg(64'h1000, 4, 2, 512, 1024, 32'h10000);
        axi_if.arready = 1;
        r_en = 1;
        start_run();
        wait_done(300, ok);
        total_cnt++;
        if (ok !== 1'b1) $display("FAIL wrap_done: got %b exp 1", ok);
        else pass_cnt++;
        total_cnt++;
        if (hs_cnt !== 8) $display("FAIL wrap_hs: got %0d exp 8", hs_cnt);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            got = (i < addr_log.size()) ? addr_log[i] : '1;
            total_cnt++;
            if (got !== exp_a[i]) $display("FAIL wrap_addr%0d: got %h exp %h", i, got, exp_a[i]);
            else pass_cnt++;
        end
        badlen = 0;
        foreach (len_log[i]) if (len_log[i] !== 8'd7) badlen++;
        total_cnt++;
        if (badlen !== 0) $display("FAIL wrap_arlen: %0d bursts not arlen 7", badlen);
        else pass_cnt++;
        total_cnt++;
        if (axi_if.arsize !== 3'd6 || axi_if.arburst !== 2'b01 || axi_if.arprot !== 3'b010)
            $display("FAIL wrap_attrs: size %0d burst %0d prot %0d exp 6 1 2",
                     axi_if.arsize, axi_if.arburst, axi_if.arprot);
        else pass_cnt++;
        total_cnt++;
        if (stat[STAT_RLAST] !== 32'd8) $display("FAIL wrap_rlasts: got %0d exp 8", stat[STAT_RLAST]);
        else pass_cnt++;
        total_cnt++;
        if (stat[STAT_BEATS] !== 32'd64) $display("FAIL wrap_beats: got %0d exp 64", stat[STAT_BEATS]);
        else pass_cnt++;
        total_cnt++;
        if (stat[STAT_FLAGS] !== 32'h20) $display("FAIL wrap_flags: got %h exp 20", stat[STAT_FLAGS]);
        else pass_cnt++;
    endtask

    task automatic test_credit_limit();
        bit ok;
        cfg(64'h2000, 16, 1, 64, 4096, 0);
        axi_if.arready = 1;
        r_en = 0;
        start_run();
        tick(20);
        total_cnt++;
        if (hs_cnt !== 4) $display("FAIL credit_cap: got %0d exp 4", hs_cnt);
        else pass_cnt++;
        total_cnt++;
        if (axi_if.arvalid !== 1'b0) $display("FAIL credit_arvalid: got %b exp 0", axi_if.arvalid);
        else pass_cnt++;
        for (int k = 1; k <= 2; k++) begin
            r_en = 1;
            tick();
            r_en = 0;
            tick(2);
            total_cnt++;
            if (hs_cnt !== 4 + k || axi_if.arvalid !== 1'b0)
                $display("FAIL credit_refill%0d: hs %0d arvalid %b exp %0d 0",
                         k, hs_cnt, axi_if.arvalid, 4 + k);
            else pass_cnt++;
        end
        r_en = 1;
        wait_done(300, ok);
        total_cnt++;
        if (ok !== 1'b1 || stat[STAT_ISSUED] !== 32'd16)
            $display("FAIL credit_finish: done %b issued %0d exp 1 16", ok, stat[STAT_ISSUED]);
        else pass_cnt++;
    endtask

    task automatic test_arready_stall();
        bit ok;
        int bad;
        logic [63:0] ea;
        ea = 64'h1_0000_0040;
        cfg(ea, 1, 1, 256, 4096, 0);
        axi_if.arready = 0;
        r_en = 1;
        start_run();
        for (int i = 0; i < 10 && axi_if.arvalid !== 1'b1; i++) tick();
        total_cnt++;
        if (axi_if.araddr !== ea || axi_if.arlen !== 8'd3 || axi_if.arvalid !== 1'b1)
            $display("FAIL stall_first: addr %h len %0d vld %b exp %h 3 1",
                     axi_if.araddr, axi_if.arlen, axi_if.arvalid, ea);
        else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (axi_if.arvalid !== 1'b1 || axi_if.araddr !== ea || axi_if.arlen !== 8'd3) bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL stall_stable: %0d unstable cycles exp 0", bad);
        else pass_cnt++;
        total_cnt++;
        if (hs_cnt !== 0) $display("FAIL stall_no_hs: got %0d exp 0", hs_cnt);
        else pass_cnt++;
        axi_if.arready = 1;
        tick(3);
        total_cnt++;
        if (hs_cnt !== 1 || axi_if.arvalid !== 1'b0)
            $display("FAIL stall_single_hs: hs %0d vld %b exp 1 0", hs_cnt, axi_if.arvalid);
        else pass_cnt++;
        wait_done(100, ok);
        total_cnt++;
        if (ok !== 1'b1 || stat[STAT_BEATS] !== 32'd4)
            $display("FAIL stall_finish: done %b beats %0d exp 1 4", ok, stat[STAT_BEATS]);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        bit ok;
        cfg(64'h4000, 8, 1, 64, 4096, 0);
        axi_if.arready = 1;
        r_en = 0;
        start_run();
        tick(15);
        total_cnt++;
        if (hs_cnt !== 4) $display("FAIL abort_pre_hs: got %0d exp 4", hs_cnt);
        else pass_cnt++;
        axi_if.arready = 0;
        r_en = 1;
        tick(2);
        r_en = 0;
        for (int i = 0; i < 10 && axi_if.arvalid !== 1'b1; i++) tick();
        ctrl[CTRL_ABORT] = 32'd1;
        tick(3);
        total_cnt++;
        if (axi_if.arvalid !== 1'b1 || hs_cnt !== 4)
            $display("FAIL abort_hold: vld %b hs %0d exp 1 4", axi_if.arvalid, hs_cnt);
        else pass_cnt++;
        axi_if.arready = 1;
        tick(2);
        total_cnt++;
        if (hs_cnt !== 5 || axi_if.arvalid !== 1'b0)
            $display("FAIL abort_last_hs: hs %0d vld %b exp 5 0", hs_cnt, axi_if.arvalid);
        else pass_cnt++;
        tick(5);
        total_cnt++;
        if (hs_cnt !== 5 || stat[STAT_FLAGS][3:0] !== 4'd2)
            $display("FAIL abort_drain: hs %0d state %0d exp 5 2", hs_cnt, stat[STAT_FLAGS][3:0]);
        else pass_cnt++;
        r_en = 1;
        wait_done(100, ok);
        total_cnt++;
        if (ok !== 1'b1 || stat[STAT_FLAGS] !== 32'h60)
            $display("FAIL abort_flags: done %b flags %h exp 1 60", ok, stat[STAT_FLAGS]);
        else pass_cnt++;
        total_cnt++;
        if (stat[STAT_ISSUED] !== 32'd5 || stat[STAT_RLAST] !== 32'd5)
            $display("FAIL abort_counts: issued %0d rlasts %0d exp 5 5",
                     stat[STAT_ISSUED], stat[STAT_RLAST]);
        else pass_cnt++;
        ctrl[CTRL_ABORT] = 32'd0;
    endtask

    task automatic test_zero_ops();
        cfg(64'h5000, 0, 3, 64, 4096, 0);
        axi_if.arready = 1;
        r_en = 1;
        start_run();
        total_cnt++;
        if (stat[STAT_FLAGS] !== 32'h13) $display("FAIL zero_busy: got %h exp 13", stat[STAT_FLAGS]);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (stat[STAT_FLAGS] !== 32'h20) $display("FAIL zero_done: got %h exp 20", stat[STAT_FLAGS]);
        else pass_cnt++;
        total_cnt++;
        if (stat[STAT_CYCLES] !== 32'd1) $display("FAIL zero_cycles: got %0d exp 1", stat[STAT_CYCLES]);
        else pass_cnt++;
        tick(3);
        total_cnt++;
        if (hs_cnt !== 0 || axi_if.arvalid !== 1'b0)
            $display("FAIL zero_no_ar: hs %0d vld %b exp 0 0", hs_cnt, axi_if.arvalid);
        else pass_cnt++;
    endtask

    task automatic test_rresp_and_reset();
        bit ok;
        int nz;
        cfg(64'h8000, 2, 1, 512, 4096, 0);
        axi_if.arready = 1;
        r_en = 1;
        err_mode = 1;
        start_run();
        wait_done(100, ok);
        total_cnt++;
        if (ok !== 1'b1 || stat[STAT_ERRORS] !== 32'd2)
            $display("FAIL rresp_errors: done %b errors %0d exp 1 2", ok, stat[STAT_ERRORS]);
        else pass_cnt++;
        total_cnt++;
        if (stat[STAT_BEATS] !== 32'd16 || stat[STAT_RLAST] !== 32'd2)
            $display("FAIL rresp_beats: beats %0d rlasts %0d exp 16 2",
                     stat[STAT_BEATS], stat[STAT_RLAST]);
        else pass_cnt++;
        err_mode = 0;
        cfg(64'h9000, 8, 1, 64, 4096, 0);
        axi_if.arready = 0;
        start_run();
        tick(5);
        total_cnt++;
        if (axi_if.arvalid !== 1'b1) $display("FAIL rst_pre_arvalid: got %b exp 1", axi_if.arvalid);
        else pass_cnt++;
        #2;
        rstn = 0;
        #1;
        total_cnt++;
        if (axi_if.arvalid !== 1'b0) $display("FAIL rst_async_arvalid: got %b exp 0", axi_if.arvalid);
        else pass_cnt++;
        nz = 0;
        for (int i = 0; i < N_STAT; i++) if (stat[i] !== 32'd0) nz++;
        total_cnt++;
        if (nz !== 0) $display("FAIL rst_status: %0d nonzero regs exp 0", nz);
        else pass_cnt++;
        tick(2);
        rstn = 1;
        axi_if.arready = 1;
        tick(2);
        total_cnt++;
        if (stat[STAT_FLAGS] !== 32'd0 || axi_if.araddr !== 64'd0)
            $display("FAIL rst_idle: flags %h addr %h exp 0 0", stat[STAT_FLAGS], axi_if.araddr);
        else pass_cnt++;
    endtask

    initial begin
        rstn = 0;
        start = 0;
        for (int i = 0; i < N_CTRL; i++) ctrl[i] = '0;
        axi_if.arready = 1;
        axi_if.awready = 0;
        axi_if.wready = 0;
        axi_if.bid = '0;
        axi_if.bresp = '0;
        axi_if.bvalid = 0;
        test_reset();
        test_wrap_addresses();
        test_credit_limit();
        test_arready_stall();
        test_abort();
        test_zero_ops();
        test_rresp_and_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
